// File: rtl/status_led_arbiter.sv
// Drives the 8 status LEDs from a blinking error code, an occupancy bargraph or the idle pattern; sources change only on display ticks.
// leds and activeSource are registered together one cycle after inputs/state change; no backpressure, errAck closes each error request.
module status_led_arbiter #(
    parameter int TICK_DIV       = 3000000,
    parameter int MIN_HOLD_TICKS = 4,
    parameter int BLINK_TICKS    = 2,
    parameter int ERR_BLINKS     = 3
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic [7:0] idlePattern,
    input  logic       levelReq,
    input  logic [7:0] level,
    input  logic       errReq,
    input  logic [7:0] errCode,
    output logic       errAck,
    output logic       errDropped,
    output logic [1:0] activeSource,
    output logic       tick,
    output logic [7:0] leds
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(MIN_HOLD_TICKS + 2);
    localparam int PW = $clog2(BLINK_TICKS + 1);
    localparam int BW = $clog2(ERR_BLINKS + 1);

    typedef enum logic [1:0] {
        SRC_IDLE  = 2'd0,
        SRC_LEVEL = 2'd1,
        SRC_ERROR = 2'd2
    } src_t;

    logic [CW-1:0] presc;
    src_t          state, state_nxt, target;
    logic [HW-1:0] hold, hold_nxt;
    logic [PW-1:0] ph_cnt, ph_cnt_nxt;
    logic          ph_on, ph_on_nxt;
    logic [BW-1:0] blink, blink_nxt;
    logic          done, done_nxt;
    logic          pend, pend_nxt;
    logic [7:0]    code, code_nxt;
    logic          ack_nxt, dropped_nxt, completing;
    logic [3:0]    bar_n;
    logic [7:0]    bar, leds_nxt;

    assign tick         = (presc == CW'(TICK_DIV - 1));
    assign activeSource = state;

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold;
        ph_cnt_nxt  = ph_cnt;
        ph_on_nxt   = ph_on;
        blink_nxt   = blink;
        done_nxt    = done;
        pend_nxt    = pend;
        code_nxt    = code;
        ack_nxt     = 1'b0;
        dropped_nxt = errDropped;
        completing  = 1'b0;
        target      = pend ? SRC_ERROR : (levelReq ? SRC_LEVEL : SRC_IDLE);

        if (tick) begin
            if (state != SRC_ERROR) begin
                if (target == SRC_ERROR) begin
                    state_nxt  = SRC_ERROR;
                    hold_nxt   = '0;
                    ph_cnt_nxt = '0;
                    ph_on_nxt  = 1'b1;
                    blink_nxt  = '0;
                    done_nxt   = 1'b0;
                end else if (target != state && hold >= HW'(MIN_HOLD_TICKS)) begin
                    state_nxt = target;
                    hold_nxt  = '0;
                end else if (hold < HW'(MIN_HOLD_TICKS)) begin
                    hold_nxt = hold + HW'(1);
                end
            end else if (done) begin
                // A request accepted after completion restarts the sequence in place.
                hold_nxt = '0;
                done_nxt = 1'b0;
                if (target == SRC_ERROR) begin
                    ph_cnt_nxt = '0;
                    ph_on_nxt  = 1'b1;
                    blink_nxt  = '0;
                end else begin
                    state_nxt = target;
                end
            end else if (ph_cnt == PW'(BLINK_TICKS - 1)) begin
                ph_cnt_nxt = '0;
                if (ph_on) begin
                    ph_on_nxt = 1'b0;
                end else if (blink == BW'(ERR_BLINKS - 1)) begin
                    completing = 1'b1;
                end else begin
                    ph_on_nxt = 1'b1;
                    blink_nxt = blink + BW'(1);
                end
            end else begin
                ph_cnt_nxt = ph_cnt + PW'(1);
            end
        end

        if (completing) begin
            ack_nxt = 1'b1;
            if (errReq) begin
                code_nxt   = errCode;
                ph_cnt_nxt = '0;
                ph_on_nxt  = 1'b1;
                blink_nxt  = '0;
            end else begin
                pend_nxt  = 1'b0;
                done_nxt  = 1'b1;
                ph_on_nxt = 1'b0;
            end
        end else if (errReq) begin
            if (!pend) begin
                pend_nxt = 1'b1;
                code_nxt = errCode;
            end else begin
                dropped_nxt = 1'b1;
            end
        end

        bar_n = 4'(({1'b0, level} + 9'd31) >> 5);
        bar   = '0;
        for (int i = 0; i < 8; i++) begin
            bar[i] = (bar_n > 4'(i));
        end

        case (state_nxt)
            SRC_LEVEL: leds_nxt = bar;
            SRC_ERROR: leds_nxt = ph_on_nxt ? code_nxt : 8'h00;
            default:   leds_nxt = idlePattern;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            presc      <= '0;
            state      <= SRC_IDLE;
            hold       <= '0;
            ph_cnt     <= '0;
            ph_on      <= 1'b0;
            blink      <= '0;
            done       <= 1'b0;
            pend       <= 1'b0;
            code       <= '0;
            errAck     <= 1'b0;
            errDropped <= 1'b0;
            leds       <= '0;
        end else begin
            presc      <= tick ? '0 : presc + CW'(1);
            state      <= state_nxt;
            hold       <= hold_nxt;
            ph_cnt     <= ph_cnt_nxt;
            ph_on      <= ph_on_nxt;
            blink      <= blink_nxt;
            done       <= done_nxt;
            pend       <= pend_nxt;
            code       <= code_nxt;
            errAck     <= ack_nxt;
            errDropped <= dropped_nxt;
            leds       <= leds_nxt;
        end
    end

endmodule
